// File: rtl/d16_uart.sv
// Memory-mapped 8N1 UART for the d16 CPU bus. TX and RX FIFOs decouple the
// serial timing from the CPU. The level interrupt is registered.
module d16_uart #(
  parameter logic [15:0] BASE_ADDR   = 16'hFF00,
  parameter int          TX_DEPTH    = 8,
  parameter int          RX_DEPTH    = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [15:0] i_wb_addr,
  input  logic        i_wb_cyc,
  input  logic        i_wb_we,
  input  logic [15:0] i_wb_dat,
  output logic [15:0] o_wb_dat,
  output logic        o_wb_ack,
  output logic        o_wb_err,
  input  logic        i_rx,
  output logic        o_tx,
  output logic        o_int
);
  localparam int TXA = $clog2(TX_DEPTH);
  localparam int RXA = $clog2(RX_DEPTH);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // Bus handshake: an access is offered by i_wb_cyc for one cycle and finishes
  // in that same cycle with exactly one of ack or err; its side effects land on
  // the clock edge that ends the cycle.
  logic        w_sel, w_wr, w_rd;
  logic [1:0]  w_reg;
  logic [15:0] w_div;

  logic [7:0]  r_tx_mem [TX_DEPTH];
  logic [TXA-1:0] r_tx_wp, r_tx_rp;
  logic [TXA:0]   r_tx_cnt;
  logic        w_tx_full, w_tx_empty, w_tx_push, w_tx_pop, w_tx_tick, w_tx_idle;
  tx_state_t   r_tx_state;
  logic [15:0] r_tx_clk, r_tx_div;
  logic [2:0]  r_tx_bit;
  logic [7:0]  r_tx_shift;
  logic        r_tx;

  logic [7:0]  r_rx_mem [RX_DEPTH];
  logic [RXA-1:0] r_rx_wp, r_rx_rp;
  logic [RXA:0]   r_rx_cnt;
  logic        w_rx_full, w_rx_empty, w_rx_push, w_rx_pop;
  rx_state_t   r_rx_state;
  logic [15:0] r_rx_clk, r_rx_div;
  logic [2:0]  r_rx_bit;
  logic [7:0]  r_rx_shift;
  logic        r_rx_s1, r_rx_s2, r_rx_d;
  logic        w_rx_fall, w_rx_half, w_rx_tick, w_rx_stop_ok, w_set_ovr, w_set_ferr;

  logic [1:0]  r_ctrl;
  logic [15:0] r_baud;
  logic        r_overrun, r_frame_err, r_int;
  logic [15:0] w_stat;

  assign w_sel = i_wb_cyc && (i_wb_addr[15:2] == BASE_ADDR[15:2]);
  assign w_reg = i_wb_addr[1:0];
  assign w_wr  = w_sel && i_wb_we;
  assign w_rd  = w_sel && !i_wb_we;
  assign w_div = (r_baud < 16'd2) ? 16'd2 : r_baud;

  assign w_tx_full  = (r_tx_cnt == TX_DEPTH[TXA:0]);
  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_tx_push  = w_wr && (w_reg == 2'd0) && !w_tx_full;
  assign w_tx_tick  = (r_tx_clk == r_tx_div - 16'd1);
  assign w_tx_pop   = !w_tx_empty &&
                      ((r_tx_state == TX_IDLE) || ((r_tx_state == TX_STOP) && w_tx_tick));
  assign w_tx_idle  = w_tx_empty && (r_tx_state == TX_IDLE);

  assign w_rx_full  = (r_rx_cnt == RX_DEPTH[RXA:0]);
  assign w_rx_empty = (r_rx_cnt == '0);
  assign w_rx_pop   = w_rd && (w_reg == 2'd0) && !w_rx_empty;
  assign w_rx_fall  = r_rx_d && !r_rx_s2;
  assign w_rx_half  = (r_rx_clk == {1'b0, r_rx_div[15:1]});
  assign w_rx_tick  = (r_rx_clk == r_rx_div - 16'd1);
  assign w_rx_stop_ok = (r_rx_state == RX_STOP) && w_rx_tick && r_rx_s2;
  assign w_rx_push  = w_rx_stop_ok && !w_rx_full;
  assign w_set_ovr  = w_rx_stop_ok && w_rx_full;
  assign w_set_ferr = (r_rx_state == RX_STOP) && w_rx_tick && !r_rx_s2;

  assign w_stat   = {10'h000, r_frame_err, r_overrun, w_tx_full, w_tx_idle,
                     w_rx_full, !w_rx_empty};
  assign o_wb_err = i_reset_n && w_wr && (w_reg == 2'd0) && w_tx_full;
  assign o_wb_ack = i_reset_n && w_sel && !(w_wr && (w_reg == 2'd0) && w_tx_full);
  assign o_tx     = r_tx;
  assign o_int    = r_int;

  always_comb begin
    o_wb_dat = 16'h0000;
    if (w_rd) begin
      case (w_reg)
        2'd0:    o_wb_dat = {8'h00, w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rp]};
        2'd1:    o_wb_dat = w_stat;
        2'd2:    o_wb_dat = {14'h0000, r_ctrl};
        default: o_wb_dat = r_baud;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wp] <= i_wb_dat[7:0];
    if (w_rx_push) r_rx_mem[r_rx_wp] <= r_rx_shift;
  end

  // FIFO bookkeeping; full/empty are always the pre-edge values.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_cnt <= '0;
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + TXA'(1);
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + TXA'(1);
      if (w_tx_push && !w_tx_pop)      r_tx_cnt <= r_tx_cnt + (TXA+1)'(1);
      else if (!w_tx_push && w_tx_pop) r_tx_cnt <= r_tx_cnt - (TXA+1)'(1);
      if (w_rx_push) r_rx_wp <= r_rx_wp + RXA'(1);
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + RXA'(1);
      if (w_rx_push && !w_rx_pop)      r_rx_cnt <= r_rx_cnt + (RXA+1)'(1);
      else if (!w_rx_push && w_rx_pop) r_rx_cnt <= r_rx_cnt - (RXA+1)'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_ctrl      <= 2'b00;
      r_baud      <= DEFAULT_DIV;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      r_int       <= 1'b0;
    end else begin
      if (w_wr && (w_reg == 2'd2)) r_ctrl <= i_wb_dat[1:0];
      if (w_wr && (w_reg == 2'd3)) r_baud <= i_wb_dat;
      // A new error on the same edge as a STAT read survives the clear.
      if (w_rd && (w_reg == 2'd1)) begin
        r_overrun   <= 1'b0;
        r_frame_err <= 1'b0;
      end
      if (w_set_ovr)  r_overrun   <= 1'b1;
      if (w_set_ferr) r_frame_err <= 1'b1;
      r_int <= (r_ctrl[0] && !w_rx_empty) || (r_ctrl[1] && w_tx_idle);
    end
  end

  // Each bit period latches the divider at its start, so BAUD writes apply
  // from the next bit onwards.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_tx_state <= TX_IDLE;
      r_tx_clk   <= 16'd0;
      r_tx_div   <= 16'd2;
      r_tx_bit   <= 3'd0;
      r_tx_shift <= 8'h00;
      r_tx       <= 1'b1;
    end else if (r_tx_state == TX_IDLE) begin
      r_tx <= 1'b1;
      if (w_tx_pop) begin
        r_tx_state <= TX_START;
        r_tx_shift <= r_tx_mem[r_tx_rp];
        r_tx_clk   <= 16'd0;
        r_tx_div   <= w_div;
        r_tx       <= 1'b0;
      end
    end else if (!w_tx_tick) begin
      r_tx_clk <= r_tx_clk + 16'd1;
    end else begin
      r_tx_clk <= 16'd0;
      r_tx_div <= w_div;
      case (r_tx_state)
        TX_START: begin
          r_tx_state <= TX_DATA;
          r_tx_bit   <= 3'd0;
          r_tx       <= r_tx_shift[0];
        end
        TX_DATA: begin
          if (r_tx_bit == 3'd7) begin
            r_tx_state <= TX_STOP;
            r_tx       <= 1'b1;
          end else begin
            r_tx_bit   <= r_tx_bit + 3'd1;
            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
            r_tx       <= r_tx_shift[1];
          end
        end
        default: begin
          if (w_tx_pop) begin
            r_tx_state <= TX_START;
            r_tx_shift <= r_tx_mem[r_tx_rp];
            r_tx       <= 1'b0;
          end else begin
            r_tx_state <= TX_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_d     <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_clk   <= 16'd0;
      r_rx_div   <= 16'd2;
      r_rx_bit   <= 3'd0;
      r_rx_shift <= 8'h00;
    end else begin
      r_rx_s1 <= i_rx;
      r_rx_s2 <= r_rx_s1;
      r_rx_d  <= r_rx_s2;
      case (r_rx_state)
        RX_IDLE: begin
          if (w_rx_fall) begin
            r_rx_state <= RX_START;
            r_rx_clk   <= 16'd0;
            r_rx_div   <= w_div;
          end
        end
        RX_START: begin
          if (w_rx_half) begin
            r_rx_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
            r_rx_clk   <= 16'd0;
            r_rx_div   <= w_div;
            r_rx_bit   <= 3'd0;
          end else begin
            r_rx_clk <= r_rx_clk + 16'd1;
          end
        end
        RX_DATA: begin
          if (w_rx_tick) begin
            r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
            r_rx_clk   <= 16'd0;
            r_rx_div   <= w_div;
            r_rx_bit   <= r_rx_bit + 3'd1;
            if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
          end else begin
            r_rx_clk <= r_rx_clk + 16'd1;
          end
        end
        default: begin
          if (w_rx_tick) r_rx_state <= RX_IDLE;
          else           r_rx_clk   <= r_rx_clk + 16'd1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_d16_uart.sv
// Directed bench for d16_uart: register access, TX framing and back-to-back
// streaming, RX reception, overrun/frame errors, interrupts and reset.
module tb_d16_uart;
  localparam int B = 4;
  localparam logic [15:0] A_DATA = 16'hFF00, A_STAT = 16'hFF01,
                          A_CTRL = 16'hFF02, A_BAUD = 16'hFF03;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] wb_addr = 16'h0000, wb_wdat = 16'h0000;
  logic        wb_cyc = 1'b0, wb_we = 1'b0;
  logic [15:0] wb_rdat;
  logic        wb_ack, wb_err;
  logic        rx = 1'b1;
  logic        tx, intr;

  int          total = 0;
  int          bad = 0;
  logic [15:0] rd;
  logic        ak, er, s_int;

  d16_uart dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_wb_addr(wb_addr), .i_wb_cyc(wb_cyc),
    .i_wb_we(wb_we), .i_wb_dat(wb_wdat), .o_wb_dat(wb_rdat), .o_wb_ack(wb_ack),
    .o_wb_err(wb_err), .i_rx(rx), .o_tx(tx), .o_int(intr)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  // One single-cycle bus access; results sampled mid-cycle.
  task automatic bus(input logic [15:0] a, input logic w, input logic [15:0] d,
                     output logic [15:0] r, output logic k, output logic e);
    @(negedge clk);
    wb_addr = a; wb_cyc = 1'b1; wb_we = w; wb_wdat = d;
    #1;
    r = wb_rdat; k = wb_ack; e = wb_err; s_int = intr;
    @(posedge clk);
    #1;
    wb_cyc = 1'b0; wb_we = 1'b0;
  endtask

  task automatic drive_rx(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rx = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (B) @(negedge clk);
    end
    rx = stop;
    repeat (B) @(negedge clk);
    rx = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // Waits for a start bit, then samples each bit 1.5 clocks into its period.
  task automatic tx_capture(output logic [9:0] bits, output int waited, output logic to);
    to = 1'b1; waited = 0; bits = '1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        waited = n; to = 1'b0;
        break;
      end
    end
    if (!to) begin
      for (int k = 0; k < 10; k++) begin
        repeat ((k == 0) ? 1 : B) @(negedge clk);
        bits[k] = tx;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL rst_tx got=%b want=1", tx); end
    total++; if (intr !== 1'b0) begin bad++; $display("FAIL rst_int got=%b want=0", intr); end
    rst_n = 1'b1;
    bus(A_STAT, 0, 0, rd, ak, er);
    total++; if (rd !== 16'h0004 || ak !== 1'b1) begin bad++; $display("FAIL rst_stat got=%h/%b want=0004/1", rd, ak); end
    bus(A_CTRL, 0, 0, rd, ak, er);
    total++; if (rd !== 16'h0000) begin bad++; $display("FAIL rst_ctrl got=%h want=0000", rd); end
    bus(A_BAUD, 0, 0, rd, ak, er);
    total++; if (rd !== 16'h0364) begin bad++; $display("FAIL rst_baud got=%h want=0364", rd); end
    bus(16'h1234, 0, 0, rd, ak, er);
    total++; if ({rd, ak, er} !== 18'h0) begin bad++; $display("FAIL unsel got=%h/%b/%b want=0000/0/0", rd, ak, er); end
    bus(16'hFF04, 0, 0, rd, ak, er);
    total++; if ({ak, er} !== 2'b00) begin bad++; $display("FAIL unsel_adj got=%b%b want=00", ak, er); end
    bus(A_DATA, 0, 0, rd, ak, er);
    total++; if (rd !== 16'h0000 || ak !== 1'b1) begin bad++; $display("FAIL rx_empty_rd got=%h/%b want=0000/1", rd, ak); end
  endtask

  task automatic test_regs();
    bus(A_CTRL, 1, 16'hFFFF, rd, ak, er);
    bus(A_CTRL, 0, 0, rd, ak, er);
    total++; if (rd !== 16'h0003) begin bad++; $display("FAIL ctrl_rw got=%h want=0003", rd); end
    bus(A_CTRL, 1, 16'h0000, rd, ak, er);
    bus(A_STAT, 1, 16'hFFFF, rd, ak, er);
    total++; if ({ak, er} !== 2'b10) begin bad++; $display("FAIL stat_wr_ack got=%b%b want=10", ak, er); end
    bus(A_STAT, 0, 0, rd, ak, er);
    total++; if (rd !== 16'h0004) begin bad++; $display("FAIL stat_wr_ign got=%h want=0004", rd); end
    bus(A_BAUD, 1, B, rd, ak, er);
    bus(A_BAUD, 0, 0, rd, ak, er);
    total++; if (rd !== 16'h0004) begin bad++; $display("FAIL baud_rw got=%h want=0004", rd); end
  endtask

  task automatic test_tx_frame();
    logic [9:0] bits; int w; logic to;
    bus(A_DATA, 1, 16'h0155, rd, ak, er);
    total++; if ({ak, er} !== 2'b10) begin bad++; $display("FAIL tx_wr_ack got=%b%b want=10", ak, er); end
    tx_capture(bits, w, to);
    total++; if (to !== 1'b0 || w !== 1) begin bad++; $display("FAIL tx_latency got=%0d/%b want=1/0", w, to); end
    total++; if (bits !== 10'b1_0101_0101_0) begin bad++; $display("FAIL tx_frame got=%b want=%b", bits, 10'b1010101010); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] fr [9]; int wt [9]; logic tos [9];
    logic ak_a [9]; logic er_a [9];
    logic [15:0] stat_busy;
    fork
      begin
        logic [15:0] r0; logic k0, e0;
        bus(A_DATA, 1, 16'h0011, r0, k0, e0);
        for (int i = 0; i < 9; i++) begin
          bus(A_DATA, 1, 16'h0020 + 16'(i), r0, k0, e0);
          ak_a[i] = k0; er_a[i] = e0;
        end
        bus(A_STAT, 0, 0, stat_busy, k0, e0);
      end
      begin
        for (int f = 0; f < 9; f++) tx_capture(fr[f], wt[f], tos[f]);
      end
    join
    for (int i = 0; i < 9; i++) begin
      total++;
      if ({ak_a[i], er_a[i]} !== ((i < 8) ? 2'b10 : 2'b01)) begin
        bad++; $display("FAIL b2b_ack[%0d] got=%b%b want=%b", i, ak_a[i], er_a[i], (i < 8) ? 2'b10 : 2'b01);
      end
    end
    total++; if (stat_busy !== 16'h0008) begin bad++; $display("FAIL b2b_full got=%h want=0008", stat_busy); end
    for (int f = 0; f < 9; f++) begin
      logic [7:0] exp_b;
      exp_b = (f == 0) ? 8'h11 : 8'h20 + 8'(f - 1);
      total++;
      if (tos[f] !== 1'b0 || fr[f] !== {1'b1, exp_b, 1'b0}) begin
        bad++; $display("FAIL b2b_frame[%0d] got=%b to=%b want=%b", f, fr[f], tos[f], {1'b1, exp_b, 1'b0});
      end
      if (f > 0) begin
        total++;
        if (wt[f] !== 2) begin bad++; $display("FAIL b2b_gap[%0d] got=%0d want=2", f, wt[f]); end
      end
    end
    repeat (4) @(negedge clk);
    bus(A_STAT, 0, 0, rd, ak, er);
    total++; if (rd !== 16'h0004) begin bad++; $display("FAIL b2b_drained got=%h want=0004", rd); end
  endtask

  task automatic test_rx_byte();
    drive_rx(8'hA3, 1'b1);
    bus(A_STAT, 0, 0, rd, ak, er);
    total++; if (rd !== 16'h0005) begin bad++; $display("FAIL rx_valid got=%h want=0005", rd); end
    bus(A_DATA, 0, 0, rd, ak, er);
    total++; if (rd !== 16'h00A3 || ak !== 1'b1) begin bad++; $display("FAIL rx_data got=%h/%b want=00a3/1", rd, ak); end
    bus(A_STAT, 0, 0, rd, ak, er);
    total++; if (rd !== 16'h0004) begin bad++; $display("FAIL rx_popped got=%h want=0004", rd); end
  endtask

  task automatic test_rx_overrun();
    for (int i = 0; i < 8; i++) bus(A_DATA, 1, 16'h0040 + 16'(i), rd, ak, er);
    for (int i = 0; i < 5; i++) drive_rx(8'h10 + 8'(i), 1'b1);
    bus(A_STAT, 0, 0, rd, ak, er);
    total++; if (rd !== 16'h0013) begin bad++; $display("FAIL ovr_stat got=%h want=0013", rd); end
    bus(A_STAT, 0, 0, rd, ak, er);
    total++; if (rd !== 16'h0003) begin bad++; $display("FAIL ovr_clear got=%h want=0003", rd); end
    for (int i = 0; i < 4; i++) begin
      bus(A_DATA, 0, 0, rd, ak, er);
      total++;
      if (rd !== 16'h0010 + 16'(i)) begin bad++; $display("FAIL ovr_data[%0d] got=%h want=%h", i, rd, 16'h0010 + 16'(i)); end
    end
    repeat (150) @(negedge clk);
    bus(A_STAT, 0, 0, rd, ak, er);
    total++; if (rd !== 16'h0004) begin bad++; $display("FAIL ovr_drained got=%h want=0004", rd); end
  endtask

  task automatic test_rx_errors();
    drive_rx(8'h5A, 1'b0);
    bus(A_STAT, 0, 0, rd, ak, er);
    total++; if (rd !== 16'h0024) begin bad++; $display("FAIL ferr_stat got=%h want=0024", rd); end
    bus(A_STAT, 0, 0, rd, ak, er);
    total++; if (rd !== 16'h0004) begin bad++; $display("FAIL ferr_clear got=%h want=0004", rd); end
    @(negedge clk); rx = 1'b0;
    @(negedge clk); rx = 1'b1;
    repeat (12) @(negedge clk);
    bus(A_STAT, 0, 0, rd, ak, er);
    total++; if (rd !== 16'h0004) begin bad++; $display("FAIL glitch got=%h want=0004", rd); end
  endtask

  task automatic test_interrupt();
    logic seen, int_before;
    bus(A_CTRL, 1, 16'h0001, rd, ak, er);
    @(negedge clk);
    total++; if (intr !== 1'b0) begin bad++; $display("FAIL int_idle got=%b want=0", intr); end
    seen = 1'b0; int_before = 1'bx;
    fork
      drive_rx(8'h3C, 1'b1);
      begin
        logic [15:0] r0; logic k0, e0;
        for (int n = 0; n < 100 && !seen; n++) begin
          bus(A_STAT, 0, 0, r0, k0, e0);
          if (r0[0] === 1'b1) begin seen = 1'b1; int_before = s_int; end
        end
      end
    join
    total++; if (seen !== 1'b1 || int_before !== 1'b0) begin bad++; $display("FAIL int_lat0 got=%b/%b want=1/0", seen, int_before); end
    bus(A_STAT, 0, 0, rd, ak, er);
    total++; if (s_int !== 1'b1) begin bad++; $display("FAIL int_rx got=%b want=1", s_int); end
    bus(A_DATA, 0, 0, rd, ak, er);
    total++; if (rd !== 16'h003C) begin bad++; $display("FAIL int_data got=%h want=003c", rd); end
    @(negedge clk);
    @(negedge clk);
    total++; if (intr !== 1'b0) begin bad++; $display("FAIL int_clr got=%b want=0", intr); end
    bus(A_CTRL, 1, 16'h0002, rd, ak, er);
    @(negedge clk);
    total++; if (intr !== 1'b0) begin bad++; $display("FAIL int_tx_lat got=%b want=0", intr); end
    @(negedge clk);
    total++; if (intr !== 1'b1) begin bad++; $display("FAIL int_tx got=%b want=1", intr); end
  endtask

  task automatic test_reset_mid_tx();
    bus(A_CTRL, 1, 16'h0003, rd, ak, er);
    bus(A_DATA, 1, 16'h0000, rd, ak, er);
    repeat (8) @(negedge clk);
    total++; if (tx !== 1'b0) begin bad++; $display("FAIL midtx_low got=%b want=0", tx); end
    rst_n = 1'b0;
    #1;
    total++; if (tx !== 1'b1 || intr !== 1'b0) begin bad++; $display("FAIL midtx_rst got=%b/%b want=1/0", tx, intr); end
    wb_addr = A_STAT; wb_cyc = 1'b1; wb_we = 1'b0;
    #1;
    total++; if ({wb_ack, wb_err} !== 2'b00) begin bad++; $display("FAIL rst_ack got=%b%b want=00", wb_ack, wb_err); end
    wb_cyc = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus(A_STAT, 0, 0, rd, ak, er);
    total++; if (rd !== 16'h0004) begin bad++; $display("FAIL midtx_stat got=%h want=0004", rd); end
    bus(A_CTRL, 0, 0, rd, ak, er);
    total++; if (rd !== 16'h0000) begin bad++; $display("FAIL midtx_ctrl got=%h want=0000", rd); end
    bus(A_BAUD, 0, 0, rd, ak, er);
    total++; if (rd !== 16'h0364) begin bad++; $display("FAIL midtx_baud got=%h want=0364", rd); end
    repeat (10) @(negedge clk);
    total++; if (tx !== 1'b1 || intr !== 1'b0) begin bad++; $display("FAIL midtx_quiet got=%b/%b want=1/0", tx, intr); end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_tx_frame();
    test_back_to_back();
    test_rx_byte();
    test_rx_overrun();
    test_rx_errors();
    test_interrupt();
    test_reset_mid_tx();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
